// File: rtl/alu_seq_ctrl.sv
// Sequencer between board switches, a 7-bit ALU and a 2-digit hex display.
// Latches operands on start, holds them for EXEC_CYCLES, then captures result/flags.
// A free-running prescaler time-multiplexes the captured result onto two digits.
module alu_seq_ctrl #(
    parameter int unsigned EXEC_CYCLES = 1,
    parameter int unsigned SCAN_DIV    = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] sw_a,
    input  logic [6:0] sw_b,
    input  logic [1:0] sw_op,
    input  logic [7:0] alu_result,
    input  logic [4:0] alu_flags,
    output logic [6:0] alu_a,
    output logic [6:0] alu_b,
    output logic [1:0] alu_op,
    output logic       busy,
    output logic       done,
    output logic [7:0] result_q,
    output logic [4:0] flags_q,
    output logic       digit_sel,
    output logic [3:0] nibble,
    output logic [7:0] anodes
);

    localparam int unsigned CntW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam int unsigned PreW = $clog2(SCAN_DIV);
    localparam logic [CntW-1:0] CntLast = CntW'(EXEC_CYCLES - 1);
    localparam logic [PreW-1:0] PreLast = PreW'(SCAN_DIV - 1);

    typedef enum logic {
        StIdle,
        StExec
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [6:0]      alu_a_q, alu_a_d;
    logic [6:0]      alu_b_q, alu_b_d;
    logic [1:0]      alu_op_q, alu_op_d;
    logic            done_q, done_d;
    logic [7:0]      result_d;
    logic [4:0]      flags_d;

    logic [PreW-1:0] pre_q, pre_d;
    logic            sel_q, sel_d;
    logic [3:0]      nib_q, nib_d;
    logic [7:0]      an_q, an_d;

    // Sequencer next-state: latch on start, count exec cycles, capture on the last one.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    alu_a_d  = sw_a;
                    alu_b_d  = sw_b;
                    alu_op_d = sw_op;
                    cnt_d    = '0;
                    state_d  = StExec;
                end
            end
            StExec: begin
                // start is deliberately not observed here: requests during EXEC are dropped.
                if (cnt_q == CntLast) begin
                    result_d = alu_result;
                    flags_d  = alu_flags;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Display scan next-state: digit flips on prescaler wrap, nibble tracks result_q every cycle.
    always_comb begin
        pre_d = (pre_q == PreLast) ? '0 : pre_q + PreW'(1);
        sel_d = (pre_q == PreLast) ? ~sel_q : sel_q;
        nib_d = sel_d ? result_q[7:4] : result_q[3:0];
        an_d  = sel_d ? 8'hFD : 8'hFE;
    end

    // Sequencer and capture registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            done_q   <= done_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    // Display scan registers; anodes reset to digit 0 so exactly one is always enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q <= '0;
            sel_q <= 1'b0;
            nib_q <= '0;
            an_q  <= 8'hFE;
        end else begin
            pre_q <= pre_d;
            sel_q <= sel_d;
            nib_q <= nib_d;
            an_q  <= an_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign busy      = (state_q == StExec);
    assign done      = done_q;
    assign digit_sel = sel_q;
    assign nibble    = nib_q;
    assign anodes    = an_q;

endmodule
